// File: rtl/pc_unit.sv
// Program-counter unit: sequential advance, stall, jump, call and return
// through a circular return-address stack that keeps the newest entries.
module pc_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       INC       = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
  input  logic [ADDR_W-1:0]                  target,
  input  logic                               clr_err,
  output logic [ADDR_W-1:0]                  pc,
  output logic [ADDR_W-1:0]                  ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ras_overflow,
  output logic                               ras_underflow
);

  localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_RET,
    OP_CALL,
    OP_JUMP,
    OP_SEQ
  } op_t;

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  top_up;
  logic [PTR_W-1:0]  top_dn;
  logic [ADDR_W-1:0] pc_inc;
  logic              empty;
  logic              full;
  logic              ovf_set;
  logic              unf_set;
  op_t               op;

  always_comb begin
    op = OP_SEQ;
    if (stall)     op = OP_HOLD;
    else if (ret)  op = OP_RET;
    else if (call) op = OP_CALL;
    else if (jump) op = OP_JUMP;
  end

  // Pointer wraps explicitly so non-power-of-two depths stay in range.
  always_comb begin
    pc_inc  = pc + ADDR_W'(INC);
    empty   = (ras_count == '0);
    full    = (ras_count == CNT_FULL);
    top_up  = (top == PTR_LAST) ? '0 : top + PTR_W'(1);
    top_dn  = (top == '0) ? PTR_LAST : top - PTR_W'(1);
    ovf_set = (op == OP_CALL) && full;
    unf_set = (op == OP_RET) && empty;
    ras_top = empty ? '0 : ras[top];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VEC;
      top           <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      ras_overflow  <= (ras_overflow  & ~clr_err) | ovf_set;
      ras_underflow <= (ras_underflow & ~clr_err) | unf_set;
      case (op)
        OP_RET: begin
          if (!empty) begin
            pc        <= ras[top];
            top       <= top_dn;
            ras_count <= ras_count - CNT_W'(1);
          end else begin
            pc <= pc_inc;
          end
        end
        // A push onto a full stack overwrites the oldest slot, which is
        // exactly the one just above the current top in the ring.
        OP_CALL: begin
          pc          <= target;
          ras[top_up] <= pc_inc;
          top         <= top_up;
          if (!full) ras_count <= ras_count + CNT_W'(1);
        end
        OP_JUMP: pc <= target;
        OP_SEQ:  pc <= pc_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized
// traffic compared against a queue-based model of the return stack.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, jump, call, ret, clr_err;
  logic [15:0] target;
  logic [15:0] pc, ras_top;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: a bounded queue, newest at the back.
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  logic        m_ovf, m_unf;

  pc_unit #(
    .ADDR_W(16),
    .INC(1),
    .RESET_VEC(16'h0000),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .jump(jump),
    .call(call),
    .ret(ret),
    .target(target),
    .clr_err(clr_err),
    .pc(pc),
    .ras_top(ras_top),
    .ras_count(ras_count),
    .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (reset) begin
      m_pc = 16'h0000;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (stall) begin
      end else if (ret) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else begin
          m_pc  = m_pc + 16'd1;
          m_unf = 1'b1;
        end
      end else if (call) begin
        m_q.push_back(m_pc + 16'd1);
        if (m_q.size() > 4) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
        m_pc = target;
      end else if (jump) begin
        m_pc = target;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; jump = 0; call = 0; ret = 0; clr_err = 0;
    target = 16'h0000;
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // then settle past the edge before anyone samples outputs.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [15:0] t);
    idle_inputs(); jump = 1; target = t; cyc(); idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1; cyc(); cyc(); idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 16'h0000 || ras_count !== 3'd0 || ras_overflow !== 1'b0 ||
        ras_underflow !== 1'b0 || ras_top !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: pc=%h cnt=%0d ovf=%b unf=%b top=%h, want 0000/0/0/0/0000",
               pc, ras_count, ras_overflow, ras_underflow, ras_top);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++;
      if (pc !== 16'(i)) begin
        failures++;
        $display("FAIL free_run[%0d]: pc=%h want %h", i, pc, 16'(i));
      end
    end
  endtask

  task automatic test_jump();
    do_jump(16'h0010);
    checks++;
    if (pc !== 16'h0010) begin
      failures++; $display("FAIL jump_setup: pc=%h want 0010", pc);
    end
    do_jump(16'h0200);
    checks++;
    if (pc !== 16'h0200 || ras_count !== 3'd0) begin
      failures++; $display("FAIL jump: pc=%h cnt=%0d want 0200/0", pc, ras_count);
    end
    cyc();
    checks++;
    if (pc !== 16'h0201) begin
      failures++; $display("FAIL jump_next: pc=%h want 0201", pc);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    do_jump(16'h0020);
    call = 1; target = 16'h0100; cyc(); idle_inputs();
    checks++;
    if (pc !== 16'h0100 || ras_top !== 16'h0021 || ras_count !== 3'd1) begin
      failures++;
      $display("FAIL call: pc=%h top=%h cnt=%0d want 0100/0021/1", pc, ras_top, ras_count);
    end
    cyc(); cyc(); cyc();
    checks++;
    if (pc !== 16'h0103) begin
      failures++; $display("FAIL pre_ret: pc=%h want 0103", pc);
    end
    ret = 1; cyc(); idle_inputs();
    checks++;
    if (pc !== 16'h0021 || ras_count !== 3'd0 || ras_top !== 16'h0000) begin
      failures++;
      $display("FAIL ret: pc=%h cnt=%0d top=%h want 0021/0/0000", pc, ras_count, ras_top);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ret [4];
    exp_ret = '{16'h4001, 16'h3001, 16'h2001, 16'h1001};
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      call = 1; target = 16'(i * 16'h1000); cyc(); idle_inputs();
    end
    checks++;
    if (ras_overflow !== 1'b1 || ras_count !== 3'd4 || pc !== 16'h5000 ||
        ras_top !== 16'h4001) begin
      failures++;
      $display("FAIL overflow: ovf=%b cnt=%0d pc=%h top=%h want 1/4/5000/4001",
               ras_overflow, ras_count, pc, ras_top);
    end
    for (int i = 0; i < 4; i++) begin
      ret = 1; cyc(); idle_inputs();
      checks++;
      if (pc !== exp_ret[i] || ras_count !== 3'(3 - i)) begin
        failures++;
        $display("FAIL lifo_ret[%0d]: pc=%h cnt=%0d want %h/%0d",
                 i, pc, ras_count, exp_ret[i], 3 - i);
      end
    end
    ret = 1; cyc(); idle_inputs();
    checks++;
    if (pc !== 16'h1002 || ras_underflow !== 1'b1 || ras_count !== 3'd0) begin
      failures++;
      $display("FAIL underflow: pc=%h unf=%b cnt=%0d want 1002/1/0",
               pc, ras_underflow, ras_count);
    end
    clr_err = 1; cyc(); idle_inputs();
    checks++;
    if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      failures++;
      $display("FAIL clr_err: ovf=%b unf=%b want 0/0", ras_overflow, ras_underflow);
    end
  endtask

  task automatic test_stall();
    do_reset();
    do_jump(16'h0050);
    stall = 1; call = 1; target = 16'h0600;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (pc !== 16'h0050 || ras_count !== 3'd0) begin
        failures++;
        $display("FAIL stall[%0d]: pc=%h cnt=%0d want 0050/0", i, pc, ras_count);
      end
    end
    stall = 0; cyc(); idle_inputs();
    checks++;
    if (pc !== 16'h0600 || ras_count !== 3'd1 || ras_top !== 16'h0051) begin
      failures++;
      $display("FAIL stall_release: pc=%h cnt=%0d top=%h want 0600/1/0051",
               pc, ras_count, ras_top);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    do_jump(16'h0030);
    call = 1; target = 16'h0700; cyc(); idle_inputs();
    ret = 1; call = 1; target = 16'h0800; cyc(); idle_inputs();
    checks++;
    if (pc !== 16'h0031 || ras_count !== 3'd0) begin
      failures++;
      $display("FAIL ret_over_call: pc=%h cnt=%0d want 0031/0", pc, ras_count);
    end
    do_jump(16'hFFFF);
    cyc();
    checks++;
    if (pc !== 16'h0000 || ras_overflow !== 1'b0) begin
      failures++; $display("FAIL wrap: pc=%h ovf=%b want 0000/0", pc, ras_overflow);
    end
    ret = 1; clr_err = 1; cyc(); idle_inputs();
    checks++;
    if (ras_underflow !== 1'b1 || pc !== 16'h0001) begin
      failures++;
      $display("FAIL clr_vs_set: unf=%b pc=%h want 1/0001", ras_underflow, pc);
    end
    call = 1; target = 16'h0900; cyc();
    reset = 1; target = 16'h0A00; cyc(); idle_inputs();
    checks++;
    if (pc !== 16'h0000 || ras_count !== 3'd0 || ras_underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_call: pc=%h cnt=%0d unf=%b want 0000/0/0",
               pc, ras_count, ras_underflow);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_top;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 99) < 2);
      stall   = ($urandom_range(0, 99) < 15);
      ret     = ($urandom_range(0, 99) < 30);
      call    = ($urandom_range(0, 99) < 35);
      jump    = ($urandom_range(0, 99) < 20);
      clr_err = ($urandom_range(0, 99) < 10);
      target  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cyc();
      exp_top = (m_q.size() > 0) ? m_q[$] : 16'h0000;
      checks++;
      if (pc !== m_pc || ras_count !== 3'(m_q.size()) || ras_top !== exp_top ||
          ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
        failures++;
        $display("FAIL random[%0d]: pc=%h cnt=%0d top=%h ovf=%b unf=%b want %h/%0d/%h/%b/%b",
                 n, pc, ras_count, ras_top, ras_overflow, ras_underflow,
                 m_pc, m_q.size(), exp_top, m_ovf, m_unf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_jump();
    test_call_ret();
    test_overflow();
    test_stall();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, want finish");
    $fatal(1);
  end

endmodule
